// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA scan controller:
//   - default 640x480@60 raster timing constants
//   - the 8-entry default palette (24-bit RGB888)
//   - axis_point(): computes an axis total and its sync window bounds
//   - default_colour(): palette ROM lookup (indices >= 8 map to black)
//   - vga_ctl_t: the control bundle that travels down the output pipeline
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_H_FP        = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BP        = 48;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_V_FP        = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BP        = 33;
    localparam int DEF_SCALE_SHIFT = 1;
    localparam int DEF_COLOUR_BITS = 3;
    localparam int DEF_MEM_LATENCY = 1;
    localparam int DEF_ADDR_W      = 17;

    localparam int PALETTE_DEPTH = 8;

    localparam logic [23:0] DEFAULT_PALETTE [PALETTE_DEPTH] = '{
        24'h000000,   // 0 black
        24'hFFFFFF,   // 1 white
        24'h0000FF,   // 2 blue
        24'hF3AD16,   // 3 buttercup
        24'hC1440E,   // 4 tia maria
        24'h008B8B,   // 5 dark cyan
        24'hFF0000,   // 6 red
        24'h00FF00    // 7 green
    };

    typedef enum logic [1:0] {
        AP_TOTAL      = 2'd0,
        AP_SYNC_START = 2'd1,
        AP_SYNC_END   = 2'd2
    } axis_point_e;

    typedef struct packed {
        logic frame_start;
        logic line_start;
        logic blank;
        logic vs;
        logic hs;
    } vga_ctl_t;

    // Total length of an axis, or the inclusive bounds of its sync pulse.
    function automatic int axis_point(input int active, input int fp, input int sync,
                                      input int bp, input axis_point_e which);
        int point;
        case (which)
            AP_TOTAL:      point = active + fp + sync + bp;
            AP_SYNC_START: point = active + fp;
            AP_SYNC_END:   point = active + fp + sync - 1;
            default:       point = 0;
        endcase
        return point;
    endfunction

    // Default palette; anything outside the table is black.
    function automatic logic [23:0] default_colour(input int idx);
        logic [23:0] colour;
        if (idx >= 0 && idx < PALETTE_DEPTH) begin
            colour = DEFAULT_PALETTE[idx[2:0]];
        end else begin
            colour = 24'h000000;
        end
        return colour;
    endfunction

endpackage

// File: rtl/vga_palette.sv
// ---------------------------------------------------------------------------
// vga_palette
// Registered palette lookup with blanking. The RGB output is the palette
// entry for pixel_colour, registered, or black when 'visible' is low.
// Optional feature macro: VGA_PALETTE_WR_EN -- when defined the palette is a
// bank of 2^COLOUR_BITS writable registers (reset to the default palette);
// otherwise it is the constant ROM from vga_pkg.
// Ports:
//   vga_clock, resetn      clock / async active-low reset
//   pixel_colour           palette index from video memory
//   visible                blank qualifier aligned with pixel_colour
//   pal_we/pal_addr/pal_data  palette write port (VGA_PALETTE_WR_EN only)
//   rgb                    registered RGB888
// ---------------------------------------------------------------------------
module vga_palette
    import vga_pkg::*;
#(
    parameter int COLOUR_BITS = DEF_COLOUR_BITS
) (
    input  logic                   vga_clock,
    input  logic                   resetn,
    input  logic [COLOUR_BITS-1:0] pixel_colour,
    input  logic                   visible,
`ifdef VGA_PALETTE_WR_EN
    input  logic                   pal_we,
    input  logic [COLOUR_BITS-1:0] pal_addr,
    input  logic [23:0]            pal_data,
`endif
    output logic [23:0]            rgb
);

    logic [23:0] entry_s;

`ifdef VGA_PALETTE_WR_EN
    localparam int DEPTH = 2 ** COLOUR_BITS;

    logic [23:0] pal_mem_r [DEPTH];

    // Writable palette bank, restored to the default palette on reset.
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                pal_mem_r[i] <= default_colour(i);
            end
        end else if (pal_we) begin
            pal_mem_r[pal_addr] <= pal_data;
        end
    end

    // Lookup reads the bank as it stands, so a write is seen next cycle.
    always_comb begin
        entry_s = pal_mem_r[pixel_colour];
    end
`else
    // Constant palette ROM.
    always_comb begin
        entry_s = default_colour(int'(pixel_colour));
    end
`endif

    // Output register; colour is forced black outside the visible area.
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            rgb <= 24'h000000;
        end else if (visible) begin
            rgb <= entry_s;
        end else begin
            rgb <= 24'h000000;
        end
    end

endmodule

// File: rtl/vga_scan_controller.sv
// ---------------------------------------------------------------------------
// vga_scan_controller
// Parametrised VGA raster generator. Counts pixels/lines, produces the
// video-memory read address (row base register + dot column, no multiplier),
// maps the returned palette index through vga_palette and delays sync,
// blank and strobes by MEM_LATENCY+1 so they line up with the colour.
// Optional feature macro: VGA_PALETTE_WR_EN (adds pal_we/pal_addr/pal_data).
// Ports:
//   vga_clock, resetn          pixel clock / async active-low reset
//   pixel_colour               palette index returned by memory
//   memory_address             combinational read address (0 when blanked)
//   VGA_R/G/B                  8-bit DAC channels
//   VGA_HS, VGA_VS             syncs at HS_POL/VS_POL during the pulse
//   VGA_BLANK                  1 = visible pixel
//   VGA_SYNC (=1), VGA_CLK (=vga_clock)
//   frame_start, line_start    strobes aligned with output pixel (0,0)/(0,y)
// ---------------------------------------------------------------------------
module vga_scan_controller
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
    parameter int COLOUR_BITS = DEF_COLOUR_BITS,
    parameter int MEM_LATENCY = DEF_MEM_LATENCY,
    parameter int ADDR_W      = DEF_ADDR_W
) (
    input  logic                   vga_clock,
    input  logic                   resetn,
    input  logic [COLOUR_BITS-1:0] pixel_colour,
`ifdef VGA_PALETTE_WR_EN
    input  logic                   pal_we,
    input  logic [COLOUR_BITS-1:0] pal_addr,
    input  logic [23:0]            pal_data,
`endif
    output logic [ADDR_W-1:0]      memory_address,
    output logic [7:0]             VGA_R,
    output logic [7:0]             VGA_G,
    output logic [7:0]             VGA_B,
    output logic                   VGA_HS,
    output logic                   VGA_VS,
    output logic                   VGA_BLANK,
    output logic                   VGA_SYNC,
    output logic                   VGA_CLK,
    output logic                   frame_start,
    output logic                   line_start
);

    localparam int H_TOTAL    = axis_point(H_ACTIVE, H_FP, H_SYNC, H_BP, AP_TOTAL);
    localparam int HS_START   = axis_point(H_ACTIVE, H_FP, H_SYNC, H_BP, AP_SYNC_START);
    localparam int HS_END     = axis_point(H_ACTIVE, H_FP, H_SYNC, H_BP, AP_SYNC_END);
    localparam int V_TOTAL    = axis_point(V_ACTIVE, V_FP, V_SYNC, V_BP, AP_TOTAL);
    localparam int VS_START   = axis_point(V_ACTIVE, V_FP, V_SYNC, V_BP, AP_SYNC_START);
    localparam int VS_END     = axis_point(V_ACTIVE, V_FP, V_SYNC, V_BP, AP_SYNC_END);
    localparam int HW         = $clog2(H_TOTAL);
    localparam int VW         = $clog2(V_TOTAL);
    localparam int H_DOTS     = H_ACTIVE >> SCALE_SHIFT;
    localparam int D          = MEM_LATENCY + 1;
    // Low SCALE_SHIFT bits of vcnt all set marks the last line of a dot row.
    localparam logic [VW-1:0] ROW_MASK = VW'((1 << SCALE_SHIFT) - 1);
    localparam vga_ctl_t CTL_IDLE = '{frame_start: 1'b0, line_start: 1'b0, blank: 1'b0,
                                      vs: ~VS_POL, hs: ~HS_POL};

    logic [HW-1:0]     hcnt_r;
    logic [VW-1:0]     vcnt_r;
    logic [ADDR_W-1:0] row_base_r;
    logic              h_last_s;
    logic              v_last_s;
    logic              h_vis_s;
    logic              v_vis_s;
    vga_ctl_t          stage_s;
    vga_ctl_t          ctl_pipe_r [D];
    logic              lookup_vis_s;
    logic [23:0]       rgb_s;

    assign h_last_s = (hcnt_r == HW'(H_TOTAL - 1));
    assign v_last_s = (vcnt_r == VW'(V_TOTAL - 1));
    assign h_vis_s  = (hcnt_r < HW'(H_ACTIVE));
    assign v_vis_s  = (vcnt_r < VW'(V_ACTIVE));

    // Raster counters: hcnt wraps every line, vcnt advances on hcnt wrap.
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            hcnt_r <= HW'(0);
            vcnt_r <= VW'(0);
        end else if (h_last_s) begin
            hcnt_r <= HW'(0);
            vcnt_r <= v_last_s ? VW'(0) : vcnt_r + VW'(1);
        end else begin
            hcnt_r <= hcnt_r + HW'(1);
        end
    end

    // Row base = y_dot*H_DOTS, built by accumulation at the end of each dot row.
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            row_base_r <= ADDR_W'(0);
        end else if (h_last_s && v_last_s) begin
            row_base_r <= ADDR_W'(0);
        end else if (h_last_s && v_vis_s && ((vcnt_r & ROW_MASK) == ROW_MASK)) begin
            row_base_r <= row_base_r + ADDR_W'(H_DOTS);
        end
    end

    // Read address for the current counter position; 0 outside active video.
    always_comb begin
        memory_address = ADDR_W'(0);
        if (h_vis_s && v_vis_s) begin
            memory_address = row_base_r + ADDR_W'(hcnt_r >> SCALE_SHIFT);
        end else begin
            memory_address = ADDR_W'(0);
        end
    end

    // Control bundle for the current counter position, before delay.
    always_comb begin
        stage_s             = CTL_IDLE;
        stage_s.blank       = h_vis_s && v_vis_s;
        stage_s.hs          = ((hcnt_r >= HW'(HS_START)) && (hcnt_r <= HW'(HS_END))) ? HS_POL : ~HS_POL;
        stage_s.vs          = ((vcnt_r >= VW'(VS_START)) && (vcnt_r <= VW'(VS_END))) ? VS_POL : ~VS_POL;
        stage_s.frame_start = (hcnt_r == HW'(0)) && (vcnt_r == VW'(0));
        stage_s.line_start  = (hcnt_r == HW'(0)) && v_vis_s;
    end

    // D-stage delay line so controls emerge with the registered colour.
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < D; i++) begin
                ctl_pipe_r[i] <= CTL_IDLE;
            end
        end else begin
            ctl_pipe_r[0] <= stage_s;
            for (int i = 1; i < D; i++) begin
                ctl_pipe_r[i] <= ctl_pipe_r[i-1];
            end
        end
    end

    // Blank qualifier as it stands when the memory data arrives.
    generate
        if (MEM_LATENCY == 0) begin : g_tap_direct
            assign lookup_vis_s = stage_s.blank;
        end else begin : g_tap_pipe
            assign lookup_vis_s = ctl_pipe_r[MEM_LATENCY-1].blank;
        end
    endgenerate

    vga_palette #(
        .COLOUR_BITS (COLOUR_BITS)
    ) u_palette (
        .vga_clock    (vga_clock),
        .resetn       (resetn),
        .pixel_colour (pixel_colour),
        .visible      (lookup_vis_s),
`ifdef VGA_PALETTE_WR_EN
        .pal_we       (pal_we),
        .pal_addr     (pal_addr),
        .pal_data     (pal_data),
`endif
        .rgb          (rgb_s)
    );

    assign VGA_R       = rgb_s[23:16];
    assign VGA_G       = rgb_s[15:8];
    assign VGA_B       = rgb_s[7:0];
    assign VGA_HS      = ctl_pipe_r[D-1].hs;
    assign VGA_VS      = ctl_pipe_r[D-1].vs;
    assign VGA_BLANK   = ctl_pipe_r[D-1].blank;
    assign frame_start = ctl_pipe_r[D-1].frame_start;
    assign line_start  = ctl_pipe_r[D-1].line_start;
    assign VGA_SYNC    = 1'b1;
    assign VGA_CLK     = vga_clock;

endmodule

// File: tb/tb_vga_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_controller
// Three instances: A small raster (MEM_LATENCY=1, SCALE_SHIFT=1), B small
// raster (MEM_LATENCY=3, SCALE_SHIFT=2, active-high syncs), C default
// 640x480 timing for the first lines. Each instance has a memory model that
// returns address[2:0] as the palette index. Expected outputs are pushed to
// a per-instance queue each cycle and popped once the pipeline delay is met.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_scan_controller;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank;
        logic        fs;
        logic        ls;
        logic [31:0] addr;
    } exp_t;

    localparam int HA  [3] = '{32, 32, 640};
    localparam int HF  [3] = '{4, 4, 16};
    localparam int HSY [3] = '{8, 4, 96};
    localparam int HB  [3] = '{4, 8, 48};
    localparam int VA  [3] = '{16, 16, 480};
    localparam int VF  [3] = '{2, 1, 10};
    localparam int VSY [3] = '{2, 3, 2};
    localparam int VB  [3] = '{3, 2, 33};
    localparam bit HP  [3] = '{1'b0, 1'b1, 1'b0};
    localparam bit VP  [3] = '{1'b0, 1'b1, 1'b0};
    localparam int SS  [3] = '{1, 2, 1};
    localparam int DL  [3] = '{2, 4, 2};

    localparam logic [23:0] REF_PAL [8] = '{24'h000000, 24'hFFFFFF, 24'h0000FF, 24'hF3AD16,
                                            24'hC1440E, 24'h008B8B, 24'hFF0000, 24'h00FF00};

    logic        vga_clock = 1'b0;
    logic        resetn    = 1'b0;
    logic        pal_we    = 1'b0;
    logic [2:0]  pal_addr  = 3'd0;
    logic [23:0] pal_data  = 24'h0;

    logic [2:0]  pc_a, pc_b, pc_c;
    logic [7:0]  addr_a;
    logic [4:0]  addr_b;
    logic [16:0] addr_c;
    logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
    logic        hs_a, vs_a, bl_a, sy_a, ck_a, fs_a, ls_a;
    logic        hs_b, vs_b, bl_b, sy_b, ck_b, fs_b, ls_b;
    logic        hs_c, vs_c, bl_c, sy_c, ck_c, fs_c, ls_c;

    int checks = 0;
    int errors = 0;
    int n = 0;
    exp_t sb [3][$];
    logic [23:0] pal_m [3][8];

    always #5 vga_clock = ~vga_clock;

    vga_scan_controller #(.H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(3), .HS_POL(1'b0), .VS_POL(1'b0),
        .SCALE_SHIFT(1), .COLOUR_BITS(3), .MEM_LATENCY(1), .ADDR_W(8)) dut_a (
        .vga_clock(vga_clock), .resetn(resetn), .pixel_colour(pc_a),
`ifdef VGA_PALETTE_WR_EN
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
`endif
        .memory_address(addr_a), .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a),
        .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK(bl_a), .VGA_SYNC(sy_a),
        .VGA_CLK(ck_a), .frame_start(fs_a), .line_start(ls_a));

    vga_scan_controller #(.H_ACTIVE(32), .H_FP(4), .H_SYNC(4), .H_BP(8),
        .V_ACTIVE(16), .V_FP(1), .V_SYNC(3), .V_BP(2), .HS_POL(1'b1), .VS_POL(1'b1),
        .SCALE_SHIFT(2), .COLOUR_BITS(3), .MEM_LATENCY(3), .ADDR_W(5)) dut_b (
        .vga_clock(vga_clock), .resetn(resetn), .pixel_colour(pc_b),
`ifdef VGA_PALETTE_WR_EN
        .pal_we(1'b0), .pal_addr(3'd0), .pal_data(24'h0),
`endif
        .memory_address(addr_b), .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b),
        .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK(bl_b), .VGA_SYNC(sy_b),
        .VGA_CLK(ck_b), .frame_start(fs_b), .line_start(ls_b));

    vga_scan_controller dut_c (
        .vga_clock(vga_clock), .resetn(resetn), .pixel_colour(pc_c),
`ifdef VGA_PALETTE_WR_EN
        .pal_we(1'b0), .pal_addr(3'd0), .pal_data(24'h0),
`endif
        .memory_address(addr_c), .VGA_R(r_c), .VGA_G(g_c), .VGA_B(b_c),
        .VGA_HS(hs_c), .VGA_VS(vs_c), .VGA_BLANK(bl_c), .VGA_SYNC(sy_c),
        .VGA_CLK(ck_c), .frame_start(fs_c), .line_start(ls_c));

    // Video memory models: index = address[2:0], returned after MEM_LATENCY.
    logic [2:0] mem_a = 3'd0;
    logic [2:0] mem_c = 3'd0;
    logic [2:0] mem_b [3] = '{3'd0, 3'd0, 3'd0};
    always @(posedge vga_clock) begin
        mem_a    <= addr_a[2:0];
        mem_c    <= addr_c[2:0];
        mem_b[0] <= addr_b[2:0];
        mem_b[1] <= mem_b[0];
        mem_b[2] <= mem_b[1];
    end
    assign pc_a = mem_a;
    assign pc_b = mem_b[2];
    assign pc_c = mem_c;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (n=%0d)", tag, obs, expv, n);
        end
    endtask

    function automatic exp_t model(input int k, input int id);
        exp_t e;
        int ht = HA[id] + HF[id] + HSY[id] + HB[id];
        int vt = VA[id] + VF[id] + VSY[id] + VB[id];
        int h  = k % ht;
        int v  = (k / ht) % vt;
        bit vis = (h < HA[id]) && (v < VA[id]);
        e.hs    = (h >= HA[id] + HF[id] && h < HA[id] + HF[id] + HSY[id]) ? HP[id] : !HP[id];
        e.vs    = (v >= VA[id] + VF[id] && v < VA[id] + VF[id] + VSY[id]) ? VP[id] : !VP[id];
        e.blank = vis;
        e.fs    = (h == 0) && (v == 0);
        e.ls    = (h == 0) && (v < VA[id]);
        e.addr  = vis ? 32'((v >> SS[id]) * (HA[id] >> SS[id]) + (h >> SS[id])) : 32'd0;
        return e;
    endfunction

    function automatic logic [29:0] obs_of(input int id);
        logic [29:0] o;
        case (id)
            0:       o = {hs_a, vs_a, bl_a, fs_a, ls_a, r_a, g_a, b_a, sy_a};
            1:       o = {hs_b, vs_b, bl_b, fs_b, ls_b, r_b, g_b, b_b, sy_b};
            default: o = {hs_c, vs_c, bl_c, fs_c, ls_c, r_c, g_c, b_c, sy_c};
        endcase
        return o;
    endfunction

    function automatic logic [31:0] addr_of(input int id);
        logic [31:0] a;
        case (id)
            0:       a = 32'(addr_a);
            1:       a = 32'(addr_b);
            default: a = 32'(addr_c);
        endcase
        return a;
    endfunction

    task automatic check_reset_all(input string tag);
        for (int id = 0; id < 3; id++) begin
            check($sformatf("%s_out%0d", tag, id), obs_of(id),
                  {!HP[id], !VP[id], 3'b000, 24'h000000, 1'b1});
            check($sformatf("%s_addr%0d", tag, id), addr_of(id), 64'd0);
        end
    endtask

    task automatic reset_model();
        for (int id = 0; id < 3; id++) begin
            sb[id].delete();
            for (int i = 0; i < 8; i++) pal_m[id][i] = REF_PAL[i];
        end
    endtask

    // One scoreboard step at the negedge where the counters sit at position n.
    task automatic tick();
        exp_t e;
        exp_t p;
        logic [23:0] rgb;
        for (int id = 0; id < 3; id++) begin
            e = model(n, id);
            sb[id].push_back(e);
            check($sformatf("addr%0d", id), addr_of(id), 64'(e.addr));
            if (sb[id].size() > DL[id]) begin
                p   = sb[id].pop_front();
                rgb = p.blank ? pal_m[id][p.addr[2:0]] : 24'h000000;
                check($sformatf("out%0d", id), obs_of(id),
                      {p.hs, p.vs, p.blank, p.fs, p.ls, rgb, 1'b1});
            end else begin
                check($sformatf("fill%0d", id), obs_of(id),
                      {!HP[id], !VP[id], 3'b000, 24'h000000, 1'b1});
            end
        end
        if (n == 5 + 3 * 800)   check("addr_c_322", addr_c, 64'd322);
        if (n == 700)           check("addr_c_hblank", addr_c, 64'd0);
        if (n == 15 * 48 + 31)  check("addr_a_max", addr_a, 64'd127);
        if (n == 15 * 48 + 31)  check("addr_b_max", addr_b, 64'd31);
    endtask

    initial begin
        reset_model();
        repeat (3) @(negedge vga_clock);
        check_reset_all("rst");
        resetn = 1'b1;
        n = 0;
        tick();
        for (int i = 1; i <= 2700; i++) begin
            @(negedge vga_clock);
            n = i;
`ifdef VGA_PALETTE_WR_EN
            if (n == 1500) begin
                pal_we   = 1'b1;
                pal_addr = 3'd5;
                pal_data = 24'h123456;
            end
`endif
            tick();
`ifdef VGA_PALETTE_WR_EN
            if (n == 1501) begin
                pal_we       = 1'b0;
                pal_m[0][5]  = 24'h123456;
            end
`endif
        end
        // Reset mid-line (instance C at hcnt=300 of line 3).
        resetn = 1'b0;
        #1;
        check_reset_all("midrst");
        repeat (2) @(negedge vga_clock);
        check_reset_all("midrst_hold");
        reset_model();
        resetn = 1'b1;
        n = 0;
        tick();
        for (int i = 1; i <= 1200; i++) begin
            @(negedge vga_clock);
            n = i;
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
